// File: rtl/video_timing_sched_if.sv
// Signal bundle between video_timing_sched, its pixel source and the HDMI controller.
interface video_timing_sched_if;
    logic        run;
    logic [23:0] pix_data;
    logic        pix_req;
    logic [11:0] pix_x;
    logic [11:0] pix_y;
    logic        frame_start;
    logic        busy;
    logic [7:0]  rgb_red;
    logic [7:0]  rgb_green;
    logic [7:0]  rgb_blue;
    logic        hsync;
    logic        vsync;
    logic        de;

    modport master (
        input  run, pix_data,
        output pix_req, pix_x, pix_y, frame_start, busy,
               rgb_red, rgb_green, rgb_blue, hsync, vsync, de
    );

    modport slave (
        output run, pix_data,
        input  pix_req, pix_x, pix_y, frame_start, busy,
               rgb_red, rgb_green, rgb_blue, hsync, vsync, de
    );
endinterface

// File: rtl/video_timing_sched.sv
// Raster timing generator: counters -> pixel request -> source-latency delay -> aligned RGB/syncs/de.
module video_timing_sched #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic                 clk_1x,
    input  logic                 sys_rst,
    video_timing_sched_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // 13-bit constants so a total of exactly 4096 still compares correctly
    localparam logic [12:0] H_ACT_C  = 13'(H_ACTIVE);
    localparam logic [12:0] HS_BEG_C = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] HS_END_C = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] H_LAST_C = 13'(H_TOTAL - 1);
    localparam logic [12:0] V_ACT_C  = 13'(V_ACTIVE);
    localparam logic [12:0] VS_BEG_C = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] VS_END_C = 13'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [12:0] V_LAST_C = 13'(V_TOTAL - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [11:0] h_cnt_q, h_cnt_d;
    logic [11:0] v_cnt_q, v_cnt_d;
    logic [12:0] h_ext, v_ext;
    logic        cnt_vld, h_wrap, frame_end;
    logic        act, hs_act, vs_act;

    assign h_ext     = {1'b0, h_cnt_q};
    assign v_ext     = {1'b0, v_cnt_q};
    assign cnt_vld   = (state_q == RUN);
    assign h_wrap    = (h_ext == H_LAST_C);
    assign frame_end = h_wrap && (v_ext == V_LAST_C);

    always_ff @(posedge clk_1x) begin
        if (sys_rst) begin
            state_q <= IDLE;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Counters fall to 0 on frame end and in IDLE, so a restart always begins at (0,0)
    always_comb begin
        state_d = state_q;
        h_cnt_d = '0;
        v_cnt_d = '0;
        case (state_q)
            IDLE: begin
                if (bus.run) state_d = RUN;
            end
            RUN: begin
                if (frame_end && !bus.run) state_d = IDLE;
                if (!h_wrap) begin
                    h_cnt_d = h_cnt_q + 12'd1;
                    v_cnt_d = v_cnt_q;
                end else if (v_ext != V_LAST_C) begin
                    v_cnt_d = v_cnt_q + 12'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign act    = cnt_vld && (h_ext < H_ACT_C) && (v_ext < V_ACT_C);
    assign hs_act = cnt_vld && (h_ext >= HS_BEG_C) && (h_ext < HS_END_C);
    assign vs_act = cnt_vld && (v_ext >= VS_BEG_C) && (v_ext < VS_END_C);

    logic        pix_req_q, frame_start_q, hs_p1_q, vs_p1_q;
    logic [11:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic        de_p2_q, hs_p2_q, vs_p2_q;
    logic        de_q, hs_q, vs_q;
    logic [23:0] rgb_q, rgb_d;

    assign pix_x_d = act ? h_cnt_q : pix_x_q;
    assign pix_y_d = act ? v_cnt_q : pix_y_q;
    assign rgb_d   = de_p2_q ? bus.pix_data : 24'h0;

    // Stage 1 issues the request, stage 2 covers source latency, stage 3 lands data with timing
    always_ff @(posedge clk_1x) begin
        if (sys_rst) begin
            pix_req_q     <= 1'b0;
            frame_start_q <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            hs_p1_q       <= 1'b0;
            vs_p1_q       <= 1'b0;
            de_p2_q       <= 1'b0;
            hs_p2_q       <= 1'b0;
            vs_p2_q       <= 1'b0;
            de_q          <= 1'b0;
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            rgb_q         <= '0;
        end else begin
            pix_req_q     <= act;
            frame_start_q <= cnt_vld && (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            hs_p1_q       <= hs_act;
            vs_p1_q       <= vs_act;
            de_p2_q       <= pix_req_q;
            hs_p2_q       <= hs_p1_q;
            vs_p2_q       <= vs_p1_q;
            de_q          <= de_p2_q;
            hs_q          <= hs_p2_q;
            vs_q          <= vs_p2_q;
            rgb_q         <= rgb_d;
        end
    end

    assign bus.pix_req     = pix_req_q;
    assign bus.pix_x       = pix_x_q;
    assign bus.pix_y       = pix_y_q;
    assign bus.frame_start = frame_start_q;
    assign bus.busy        = cnt_vld;
    assign bus.de          = de_q;
    assign bus.rgb_red     = rgb_q[23:16];
    assign bus.rgb_green   = rgb_q[15:8];
    assign bus.rgb_blue    = rgb_q[7:0];
    assign bus.hsync       = hs_q ? HS_POL : ~HS_POL;
    assign bus.vsync       = vs_q ? VS_POL : ~VS_POL;
endmodule

// File: tb/tb_video_timing_sched.sv
// Self-checking bench for video_timing_sched using a frame-position reference model.
`timescale 1ns/1ps
module tb_video_timing_sched;
    localparam int HA = 8, HF = 2, HS = 3, HB = 3;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    logic clk_1x = 1'b0;
    logic sys_rst;
    video_timing_sched_if bus();

    video_timing_sched #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .clk_1x (clk_1x),
        .sys_rst(sys_rst),
        .bus    (bus)
    );

    always #5 clk_1x = ~clk_1x;

    // Pixel source: answers a request one cycle later, otherwise drives noise
    always @(posedge clk_1x) begin
        if (bus.pix_req === 1'b1) bus.pix_data <= {bus.pix_y[7:0], bus.pix_x[7:0], 8'hA5};
        else                      bus.pix_data <= 24'($urandom);
    end

    int vectors = 0;
    int miscompares = 0;
    int cyc_n = 0;
    // ph[k]: position within frame (0..FT-1) of the counters k cycles ago, -1 when stopped
    int ph [4];
    int mx, my;

    typedef struct packed {
        logic        req;
        logic [11:0] x;
        logic [11:0] y;
        logic        fs;
        logic        busy;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic        hs;
        logic        vs;
        logic        de;
    } obs_t;

    function automatic bit m_req(int p);
        return p >= 0 && (p % HT) < HA && (p / HT) < VA;
    endfunction
    function automatic bit m_hs(int p);
        return p >= 0 && (p % HT) >= HA + HF && (p % HT) < HA + HF + HS;
    endfunction
    function automatic bit m_vs(int p);
        return p >= 0 && (p / HT) >= VA + VF && (p / HT) < VA + VF + VS;
    endfunction

    function automatic obs_t exp_vec();
        obs_t e;
        e.req  = m_req(ph[1]);
        e.x    = 12'(mx);
        e.y    = 12'(my);
        e.fs   = (ph[1] == 0);
        e.busy = (ph[0] >= 0);
        e.de   = m_req(ph[3]);
        if (e.de) begin
            e.r = 8'(ph[3] / HT);
            e.g = 8'(ph[3] % HT);
            e.b = 8'hA5;
        end else begin
            e.r = 8'h0;
            e.g = 8'h0;
            e.b = 8'h0;
        end
        e.hs = !m_hs(ph[3]);
        e.vs = !m_vs(ph[3]);
        return e;
    endfunction

    function automatic obs_t dut_vec();
        obs_t o;
        o.req  = bus.pix_req;
        o.x    = bus.pix_x;
        o.y    = bus.pix_y;
        o.fs   = bus.frame_start;
        o.busy = bus.busy;
        o.r    = bus.rgb_red;
        o.g    = bus.rgb_green;
        o.b    = bus.rgb_blue;
        o.hs   = bus.hsync;
        o.vs   = bus.vsync;
        o.de   = bus.de;
        return o;
    endfunction

    task automatic model_step(input bit rst, input bit r);
        int nxt;
        if (rst) begin
            ph = '{-1, -1, -1, -1};
            mx = 0;
            my = 0;
        end else begin
            if (ph[0] < 0)                    nxt = r ? 0 : -1;
            else if (ph[0] == FT - 1 && !r)   nxt = -1;
            else                              nxt = (ph[0] + 1) % FT;
            ph[3] = ph[2];
            ph[2] = ph[1];
            ph[1] = ph[0];
            ph[0] = nxt;
            if (m_req(ph[1])) begin
                mx = ph[1] % HT;
                my = ph[1] / HT;
            end
        end
    endtask

    task automatic tick(input bit r, input bit rst);
        bus.run = r;
        sys_rst = rst;
        model_step(rst, r);
        @(negedge clk_1x);
        cyc_n++;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 53; i++) begin
            tick(1'b0, i < 3);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL reset_vec cyc=%0d got=%h exp=%h", cyc_n, dut_vec(), exp_vec());
            end
            vectors++;
            if ({bus.hsync, bus.vsync, bus.de, bus.busy, bus.pix_req, bus.rgb_red, bus.rgb_green, bus.rgb_blue}
                !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0}) begin
                miscompares++;
                $display("FAIL reset_idle cyc=%0d got hs=%b vs=%b de=%b busy=%b req=%b rgb=%h, want 1 1 0 0 0 000000",
                         cyc_n, bus.hsync, bus.vsync, bus.de, bus.busy, bus.pix_req,
                         {bus.rgb_red, bus.rgb_green, bus.rgb_blue});
            end
        end
    endtask

    task automatic test_frame();
        int reqs;
        int fss;
        int de_cnt [VT];
        reqs = 0;
        fss = 0;
        for (int l = 0; l < VT; l++) de_cnt[l] = 0;
        tick(1'b1, 1'b0);
        vectors++;
        if (dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL frame_entry cyc=%0d got=%h exp=%h", cyc_n, dut_vec(), exp_vec());
        end
        for (int i = 0; i < FT + 2; i++) begin
            tick(1'b1, 1'b0);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL frame_vec cyc=%0d got=%h exp=%h", cyc_n, dut_vec(), exp_vec());
            end
            if (i < FT && bus.pix_req === 1'b1) reqs++;
            if (i < FT && bus.frame_start === 1'b1) fss++;
            if (i >= 2 && bus.de === 1'b1) de_cnt[(i - 2) / HT]++;
            if (i - 2 == 2 * HT + 5) begin
                vectors++;
                if ({bus.de, bus.rgb_red, bus.rgb_green, bus.rgb_blue} !== {1'b1, 8'd2, 8'd5, 8'hA5}) begin
                    miscompares++;
                    $display("FAIL pixel_5_2 got de=%b rgb=%h want de=1 rgb=0205a5",
                             bus.de, {bus.rgb_red, bus.rgb_green, bus.rgb_blue});
                end
            end
        end
        vectors++;
        if (reqs !== 32) begin
            miscompares++;
            $display("FAIL req_count got=%0d want=32", reqs);
        end
        vectors++;
        if (fss !== 1) begin
            miscompares++;
            $display("FAIL fs_count got=%0d want=1", fss);
        end
        for (int l = 0; l < VT; l++) begin
            vectors++;
            if (de_cnt[l] !== ((l < VA) ? HA : 0)) begin
                miscompares++;
                $display("FAIL de_per_line line=%0d got=%0d want=%0d", l, de_cnt[l], (l < VA) ? HA : 0);
            end
        end
    endtask

    task automatic test_sync();
        logic pde, phs, pvs;
        int de_rise, hs_fall, vs_fall, n_hs, n_vs;
        pde = bus.de; phs = bus.hsync; pvs = bus.vsync;
        de_rise = -100000; hs_fall = -1; vs_fall = -1; n_hs = 0; n_vs = 0;
        for (int i = 0; i < 2 * FT; i++) begin
            tick(1'b1, 1'b0);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL sync_vec cyc=%0d got=%h exp=%h", cyc_n, dut_vec(), exp_vec());
            end
            if (!pde && bus.de) de_rise = cyc_n;
            if (phs && !bus.hsync) begin
                hs_fall = cyc_n;
                n_hs++;
                if (cyc_n - de_rise < HT) begin
                    vectors++;
                    if (cyc_n - de_rise !== HA + HF) begin
                        miscompares++;
                        $display("FAIL hs_offset got=%0d want=%0d", cyc_n - de_rise, HA + HF);
                    end
                end
            end
            if (!phs && bus.hsync && hs_fall >= 0) begin
                vectors++;
                if (cyc_n - hs_fall !== HS) begin
                    miscompares++;
                    $display("FAIL hs_width got=%0d want=%0d", cyc_n - hs_fall, HS);
                end
            end
            if (pvs && !bus.vsync) begin
                vs_fall = cyc_n;
                n_vs++;
                vectors++;
                if (cyc_n - de_rise !== 2 * HT) begin
                    miscompares++;
                    $display("FAIL vs_offset got=%0d want=%0d", cyc_n - de_rise, 2 * HT);
                end
            end
            if (!pvs && bus.vsync && vs_fall >= 0) begin
                vectors++;
                if (cyc_n - vs_fall !== VS * HT) begin
                    miscompares++;
                    $display("FAIL vs_width got=%0d want=%0d", cyc_n - vs_fall, VS * HT);
                end
            end
            pde = bus.de; phs = bus.hsync; pvs = bus.vsync;
        end
        vectors++;
        if (n_hs !== 2 * VT || n_vs !== 2) begin
            miscompares++;
            $display("FAIL sync_counts got hs=%0d vs=%0d want hs=%0d vs=2", n_hs, n_vs, 2 * VT);
        end
    endtask

    task automatic test_continuous();
        int last_fs, n_fs;
        last_fs = -1; n_fs = 0;
        for (int i = 0; i < 3 * FT; i++) begin
            tick(1'b1, 1'b0);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL cont_vec cyc=%0d got=%h exp=%h", cyc_n, dut_vec(), exp_vec());
            end
            if (bus.frame_start === 1'b1) begin
                n_fs++;
                if (last_fs >= 0) begin
                    vectors++;
                    if (cyc_n - last_fs !== FT) begin
                        miscompares++;
                        $display("FAIL fs_period got=%0d want=%0d", cyc_n - last_fs, FT);
                    end
                end
                last_fs = cyc_n;
            end
        end
        vectors++;
        if (n_fs !== 3) begin
            miscompares++;
            $display("FAIL fs_pulses got=%0d want=3", n_fs);
        end
    endtask

    task automatic test_stop();
        int fall, reqs, late_reqs;
        fall = -1; reqs = 0; late_reqs = 0;
        for (int k = 0; k < 2 * FT && ph[0] != 40; k++) tick(1'b1, 1'b0);
        vectors++;
        if (ph[0] !== 40) begin
            miscompares++;
            $display("FAIL stop_sync got phase=%0d want=40", ph[0]);
        end
        for (int k = 1; k <= 100; k++) begin
            tick(1'b0, 1'b0);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL stop_vec cyc=%0d got=%h exp=%h", cyc_n, dut_vec(), exp_vec());
            end
            if (bus.pix_req === 1'b1) begin
                reqs++;
                if (fall >= 0) late_reqs++;
            end
            if (bus.busy !== 1'b1 && fall < 0) fall = k;
        end
        vectors++;
        if (fall !== FT - 40) begin
            miscompares++;
            $display("FAIL stop_busy_fall got=%0d want=%0d", fall, FT - 40);
        end
        vectors++;
        if (reqs !== HA || late_reqs !== 0) begin
            miscompares++;
            $display("FAIL stop_reqs got=%0d/%0d want=%0d/0", reqs, late_reqs, HA);
        end
    endtask

    task automatic test_back_to_back();
        int idle_cycles;
        bit r;
        idle_cycles = 0;
        tick(1'b1, 1'b0);
        for (int k = 0; k < 300; k++) begin
            r = !(k < FT && ph[0] >= 60 && ph[0] < 90);
            tick(r, 1'b0);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL b2b_vec cyc=%0d got=%h exp=%h", cyc_n, dut_vec(), exp_vec());
            end
            if (bus.busy !== 1'b1) idle_cycles++;
        end
        vectors++;
        if (idle_cycles !== 0) begin
            miscompares++;
            $display("FAIL b2b_gap got=%0d idle cycles want=0", idle_cycles);
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 2 * FT && ph[0] != HT + 3; k++) tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        vectors++;
        if ({bus.de, bus.hsync, bus.pix_req, bus.busy} !== 4'b0100) begin
            miscompares++;
            $display("FAIL rst_mid got de=%b hs=%b req=%b busy=%b want 0 1 0 0",
                     bus.de, bus.hsync, bus.pix_req, bus.busy);
        end
        tick(1'b1, 1'b0);
        vectors++;
        if ({bus.busy, bus.frame_start} !== 2'b10) begin
            miscompares++;
            $display("FAIL rst_run_entry got busy=%b fs=%b want 1 0", bus.busy, bus.frame_start);
        end
        tick(1'b1, 1'b0);
        vectors++;
        if ({bus.frame_start, bus.pix_req, bus.pix_x, bus.pix_y} !== {1'b1, 1'b1, 24'h0}) begin
            miscompares++;
            $display("FAIL rst_restart got fs=%b req=%b x=%0d y=%0d want 1 1 0 0",
                     bus.frame_start, bus.pix_req, bus.pix_x, bus.pix_y);
        end
        vectors++;
        if (dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL rst_vec cyc=%0d got=%h exp=%h", cyc_n, dut_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        bit r, rst;
        r = 1'b1;
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 23) == 0) r = !r;
            rst = ($urandom_range(0, 149) == 0);
            tick(r, rst);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL random_vec cyc=%0d got=%h exp=%h", cyc_n, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        ph = '{-1, -1, -1, -1};
        mx = 0;
        my = 0;
        bus.run = 1'b0;
        sys_rst = 1'b1;
        test_reset();
        test_frame();
        test_sync();
        test_continuous();
        test_stop();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
